uart_rx: RTL
============

# uart_rx

UART receiver: recovers 8N1 frames (start bit 0, 8 data bits LSB first, one stop bit 1) from an asynchronous serial line and writes each good byte into the RX FIFO. Sits between the `uart_rx_i` pad and the RX FIFO write port, mirroring the transmitter on the TX side. Bit timing comes from an external oversampling enable. The block reports framing and overrun errors as single-cycle pulses.

## Interface
- `OVERSAMPLE`, 16: `rx_en_i` ticks per bit period; must be even and ≥ 4.
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `rx_en_i`  in  1  oversample tick, one-cycle pulse at `OVERSAMPLE` × baud.
- `uart_rx_i`  in  1  serial line, asynchronous to `clk_i`, idles high.
- `rx_fifo_full_i`  in  1  RX FIFO full.
- `rx_fifo_data_o`  out  8  received byte; valid while `rx_fifo_wr_en_o` is high.
- `rx_fifo_wr_en_o`  out  1  one-cycle write strobe to the RX FIFO.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun_err_o`  out  1  one-cycle pulse: good byte dropped because the FIFO is full.

## Operation
- `uart_rx_i` passes through a 2-flop synchronizer (both flops reset to 1). All decisions use the synchronized value `rx_s`.
- Internal state:
  - `tick_cnt`: $clog2(OVERSAMPLE) bits.
  - `bit_count`: 3 bits.
  - `shift`: 8 bits.
- The FSM advances only on cycles with `rx_en_i`=1. Otherwise all state holds.
- `S_IDLE`: on a tick with `rx_s`=0, go to `S_START` and clear `tick_cnt`.
- `S_START`: on each tick, `tick_cnt`++. When `tick_cnt` == OVERSAMPLE/2−1 (mid start bit):
  - `rx_s`=0: go to `S_DATA` and clear `tick_cnt` and `bit_count`.
  - `rx_s`=1: false start; return to `S_IDLE` with no output.
- `S_DATA`: when `tick_cnt` == OVERSAMPLE−1 (mid bit):
  - `shift[bit_count]` <= `rx_s`, clear `tick_cnt`.
  - If `bit_count`==7, go to `S_STOP`; otherwise `bit_count`++.
- `S_STOP`: when `tick_cnt` == OVERSAMPLE−1:
  - `rx_s`=1 and `rx_fifo_full_i`=0: `rx_fifo_data_o` <= `shift`, `rx_fifo_wr_en_o` <= 1, go to `S_IDLE`.
  - `rx_s`=1 and `rx_fifo_full_i`=1: `overrun_err_o` <= 1, no write, byte discarded, go to `S_IDLE`.
  - `rx_s`=0: `frame_err_o` <= 1, no write, go to `S_WAIT_HIGH`.
- `S_WAIT_HIGH`: on a tick with `rx_s`=1, go to `S_IDLE`. A break (line held low) therefore yields exactly one `frame_err_o` pulse, not repeated frames.
- `rx_fifo_full_i` is sampled only on the stop-bit decision tick.
- Pulse outputs (`rx_fifo_wr_en_o`, `frame_err_o`, `overrun_err_o`):
  - Default to 0 on every clock, independent of `rx_en_i`; each is high for exactly one `clk_i` cycle.
  - At most one of the three is high in any cycle.
- `rx_fifo_data_o` holds the last written byte until the next write.
- Reset, including mid-frame:
  - FSM to `S_IDLE`; all counters and `shift` to 0.
  - Outputs: `rx_fifo_data_o`=0x00, `rx_fifo_wr_en_o`=0, `frame_err_o`=0, `overrun_err_o`=0.
  - Synchronizer flops to 1.
  - A partially received frame is discarded. After reset the receiver resynchronizes on the next falling edge seen in `S_IDLE`. It may misframe if reset releases mid-byte; this is accepted.

## Timing
- Synchronizer latency: 2 `clk_i` cycles from a `uart_rx_i` change to `rx_s`.
- Start edge is detected on the first tick after `rx_s` falls; sampling points then follow at OVERSAMPLE/2 and OVERSAMPLE/2 + k·OVERSAMPLE ticks after detection (k=1..9).
- `rx_fifo_wr_en_o`, `frame_err_o` and `overrun_err_o` rise on the `clk_i` edge after the tick that samples the stop bit: 9.5 bit periods + ≤1 tick + 2 clks after the line falls.
- Back-to-back frames: a new start bit is accepted from the tick after the stop decision, so ≥ 0.5 bit of stop margin is tolerated.
- Baud tolerance: ±4% mismatch between sender and tick rate at OVERSAMPLE=16.

## Structure
- `uart_pkg` holds:
  - `uart_rx_state_t` enum {`S_IDLE`, `S_START`, `S_DATA`, `S_STOP`, `S_WAIT_HIGH`}.
  - `UART_DATA_BITS`=8.
  - Default `UART_OVERSAMPLE`=16.
- Sub-module `uart_sync`: parameterized 2-flop synchronizer with a reset value parameter (1 here). It is reusable for other async inputs.
- `uart_rx` contains the FSM, counters, shift register and output registers.

## Test plan
- Tick every 4 clks, OVERSAMPLE=16; drive byte 0xA5 as an 8N1 frame → exactly one `rx_fifo_wr_en_o` pulse with `rx_fifo_data_o`=0xA5; no error pulses.
- Back-to-back frames 0x00, 0xFF, 0x3C with a 1-bit stop only → three writes in order 0x00, 0xFF, 0x3C.
- Low glitch of 3 ticks on an idle line → no write, no error; a following 0x55 frame is received correctly.
- Frame 0x81 with stop bit 0, then the line held low 20 bit times, then released → one `frame_err_o` pulse, no write; a following 0x42 is received as 0x42.
- `rx_fifo_full_i`=1 during frame 0x7E → one `overrun_err_o` pulse, no write, `rx_fifo_data_o` unchanged.
- Assert `rst_i` for 1 clk at data bit 4 of frame 0x99 → all outputs reset at once; a clean 0x66 sent after line idle is received as 0x66.
- Loopback with the team's UART transmitter: the TX bit enable is the RX tick divided by 16; 256 sequential bytes 0x00..0xFF in → identical bytes out, zero errors.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: the receiver FSM state type,
// the data width of a frame and the default oversampling ratio.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Number of data bits in an 8N1 frame.
    localparam int UART_DATA_BITS  = 8;

    // Default number of rx_en_i ticks per bit period.
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for an asynchronous input. Both flops load RESET_VAL
// on reset so an idle-high line does not look like an edge after reset.
// Ports:
//   clk_i  in  clock
//   rst_i  in  synchronous active-high reset
//   d_i    in  asynchronous input
//   q_o    out synchronized output (2 cycles latency)
// -----------------------------------------------------------------------------
module uart_sync #(
    parameter int          WIDTH     = 1,
    parameter logic [0:0]  RESET_VAL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= {WIDTH{RESET_VAL}};
            sync_q <= {WIDTH{RESET_VAL}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The serial line is synchronized, then a tick-driven FSM
// finds the start bit, samples each bit at its centre and writes good bytes to
// the RX FIFO. Framing and overrun errors are reported as one-cycle pulses.
// Ports:
//   clk_i            in  system clock
//   rst_i            in  synchronous active-high reset
//   rx_en_i          in  oversample tick (OVERSAMPLE per bit period)
//   uart_rx_i        in  asynchronous serial line, idles high
//   rx_fifo_full_i   in  RX FIFO full
//   rx_fifo_data_o   out received byte, holds until the next write
//   rx_fifo_wr_en_o  out one-cycle FIFO write strobe
//   frame_err_o      out one-cycle pulse: stop bit sampled low
//   overrun_err_o    out one-cycle pulse: good byte dropped, FIFO full
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rx_en_i,
    input  logic                      uart_rx_i,
    input  logic                      rx_fifo_full_i,
    output logic [UART_DATA_BITS-1:0] rx_fifo_data_o,
    output logic                      rx_fifo_wr_en_o,
    output logic                      frame_err_o,
    output logic                      overrun_err_o
);

    localparam int TW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (uart_rx_i),
        .q_o   (rx_s)
    );

    uart_rx_state_t            state_q,    state_d;
    logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
    logic [2:0]                bit_cnt_q,  bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q,    shift_d;
    logic [UART_DATA_BITS-1:0] data_q,     data_d;
    logic                      wr_en_q,    wr_en_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q,  overrun_d;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        // Pulses drop every clock, so each lasts exactly one cycle even
        // though the FSM itself only moves on ticks.
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (rx_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end

                S_START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        // Centre of the start bit: a line back high means a
                        // glitch, not a frame.
                        if (!rx_s) begin
                            state_d    = S_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end

                S_DATA: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        shift_d[bit_cnt_q] = rx_s;
                        tick_cnt_d         = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end

                S_STOP: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            state_d = S_IDLE;
                            if (rx_fifo_full_i) begin
                                overrun_d = 1'b1;
                            end else begin
                                data_d  = shift_q;
                                wr_en_d = 1'b1;
                            end
                        end else begin
                            // Park until the line returns high so a held-low
                            // break reports a single framing error.
                            frame_err_d = 1'b1;
                            state_d     = S_WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end

                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_fifo_data_o  = data_q;
    assign rx_fifo_wr_en_o = wr_en_q;
    assign frame_err_o     = frame_err_q;
    assign overrun_err_o   = overrun_q;

endmodule
